// File: rtl/cla_pipe_subtractor_if.sv
// cla_pipe_subtractor_if: operand/result valid-ready bundle for the pipelined subtractor
interface cla_pipe_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, ovf, zero);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, ovf, zero);
endinterface

// File: rtl/cla_pipe_subtractor.sv
// cla_pipe_subtractor: a - b - bin as a + ~b + ~bin, one 4-bit lookahead slice per pipeline stage
module cla_pipe_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  cla_pipe_subtractor_if.slave s
);
  localparam int STAGES = WIDTH / 4;

  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g = x & y;
    p = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_bout, r_ovf, r_zero;

  logic [WIDTH-1:0] w_xa [STAGES];
  logic [WIDTH-1:0] w_xb [STAGES];
  logic [WIDTH-1:0] w_xs [STAGES];
  logic [WIDTH-1:0] w_ns [STAGES];
  logic             w_xc [STAGES];
  logic             w_xv [STAGES];
  logic             w_c4 [STAGES];
  logic             w_c3 [STAGES];
  logic [5:0]       w_r  [STAGES];
  logic             w_en;

  assign w_en        = ~r_v[STAGES-1] | s.out_ready;
  assign s.in_ready  = w_en;
  assign s.out_valid = r_v[STAGES-1];
  assign s.diff      = r_s[STAGES-1];
  assign s.bout      = r_bout;
  assign s.ovf       = r_ovf;
  assign s.zero      = r_zero;

  // stage k sees the raw inputs (k = 0) or the previous stage's skewed operands and partial sum
  always_comb begin
    w_xa[0] = s.a;
    w_xb[0] = s.b;
    w_xs[0] = '0;
    w_xc[0] = ~s.bin;
    w_xv[0] = s.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_xa[k] = r_a[k-1];
      w_xb[k] = r_b[k-1];
      w_xs[k] = r_s[k-1];
      w_xc[k] = r_c[k-1];
      w_xv[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_r[k]          = cla4(w_xa[k][4*k +: 4], ~w_xb[k][4*k +: 4], w_xc[k]);
      w_ns[k]         = w_xs[k];
      w_ns[k][4*k +: 4] = w_r[k][3:0];
      w_c4[k]         = w_r[k][4];
      w_c3[k]         = w_r[k][5];
    end
  end

  // data only moves with a valid beat, so bubbles never overwrite held results with junk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= w_xv[k];
        if (w_xv[k]) begin
          r_a[k] <= w_xa[k];
          r_b[k] <= w_xb[k];
          r_s[k] <= w_ns[k];
          r_c[k] <= w_c4[k];
        end
      end
      if (w_xv[STAGES-1]) begin
        r_bout <= ~w_c4[STAGES-1];
        r_ovf  <= w_c3[STAGES-1] ^ w_c4[STAGES-1];
        r_zero <= ~|w_ns[STAGES-1];
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// tb_cla_pipe_subtractor: directed vectors plus random traffic against a queued scoreboard
module tb_cla_pipe_subtractor;
  typedef struct packed {logic [15:0] d; logic bo; logic ov; logic z;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_subtractor_if #(.WIDTH(16)) bus();
  cla_pipe_subtractor #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .s(bus));

  exp_t q[$];
  int   oc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_or = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic ov, input logic z);
    return exp_t'({d, bo, ov, z});
  endfunction

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    logic [16:0] t;
    int sv;
    t  = {1'b0, ta} - {1'b0, tb} - {16'd0, tbin};
    sv = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
    return mk(t[15:0], t[16], (sv > 32767) || (sv < -32768), t[15:0] == 16'd0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual diff=%h required none", bus.diff);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", 32'({bus.diff, bus.bout, bus.ovf, bus.zero}), 32'(e));
      end
      oc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_or) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      input exp_t e, output int tacc);
    int n;
    bit rdy;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb;
    bus.bin = tbin;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      step();
      if (rdy) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual in_ready=0 required 1");
        bus.in_valid = 1'b0;
        tacc = cyc;
        return;
      end
    end
    q.push_back(e);
    tacc = cyc;
    bus.in_valid = 1'b0;
    bus.a = 'x;
    bus.b = 'x;
    bus.bin = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1);
  end

  initial begin
    int t0, td, n;
    logic [15:0] ra, rb;
    logic rbin;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_flags", 32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    oc.delete();
    send(16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 0, 0, 0), t0);
    send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1, 0, 0), td);
    send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 1, 0), td);
    send(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1, 1, 0), td);
    send(16'h0005, 16'h0005, 1'b1, mk(16'hFFFF, 1, 0, 0), td);
    send(16'hABCD, 16'hABCD, 1'b0, mk(16'h0000, 0, 0, 1), td);
    drain();
    check("lat_first", 32'((oc.size() > 0) ? oc[0] + 1 - t0 : -1), 32'd4);

    oc.delete();
    for (int i = 0; i < 8; i++) begin
      send(16'(i * 16'h1111), 16'(i), 1'b0, mk(16'(i * 16'h1110), 0, 0, i == 0), td);
      if (i == 0) t0 = td;
    end
    drain();
    check("b2b_count", 32'(oc.size()), 32'd8);
    if (oc.size() == 8) begin
      check("b2b_lat", 32'(oc[0] + 1 - t0), 32'd4);
      for (int j = 1; j < 8; j++) check("b2b_consec", 32'(oc[j] - oc[0]), 32'(j));
    end

    bus.out_ready = 1'b0;
    send(16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 0, 0, 0), td);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_diff", 32'(bus.diff), 32'h0FFF);
      check("stall_hold", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    drain();

    send(16'h1111, 16'h0001, 1'b0, model(16'h1111, 16'h0001, 1'b0), td);
    send(16'h2222, 16'h0002, 1'b0, model(16'h2222, 16'h0002, 1'b0), td);
    send(16'h3333, 16'h0003, 1'b1, model(16'h3333, 16'h0003, 1'b1), td);
    rst_n = 1'b0;
    q.delete();
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      check("post_rst_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst_out", 32'({bus.diff, bus.bout, bus.ovf, bus.zero}), 32'd0);
      step();
    end

    rnd_or = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) step();
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (i % 10 == 0) rb = ra;
      send(ra, rb, rbin, model(ra, rb, rbin), td);
    end
    rnd_or = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (8) step();
    check("final_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
